// File: rtl/usb_rx_param.sv
// USB full-speed packet receiver: line synchronisation, bit-timer recovery,
// NRZI decode, bit unstuffing, SYNC check, EOP detection, byte assembly and
// a configurable byte FIFO with exact occupancy count and sticky error flags.
module usb_rx_param #(
    parameter int         CLKS_PER_BIT = 8,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          d_plus,
    input  logic                          d_minus,
    input  logic                          r_enable,
    output logic [7:0]                    r_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          rcving,
    output logic                          r_error,
    output logic                          stuff_error,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_MID = TW'(CLKS_PER_BIT / 2);
    // Idle J level for {d_plus, d_minus}
    localparam logic [1:0] LINE_J = 2'b10;

    typedef enum logic [2:0] {IDLE, SYNC, RECV, ERR_WAIT, EOP_WAIT} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      line_raw, line_meta, line_sync;
    logic            dp_sync, dm_sync, dp_prev_reg;
    logic [TW-1:0]   timer_reg;
    logic [2:0]      bit_cnt_reg, ones_reg;
    logic [7:0]      shift_reg, new_byte;
    logic            last_reg;
    logic            wr_pending_reg;
    logic [7:0]      wr_byte_reg;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [7:0]      mem [FIFO_DEPTH];
    logic            r_error_reg, stuff_error_reg, overflow_reg;

    logic dp_edge, dp_fall, strobe, eop, j_seen, dec_bit, stuff_slot, start;
    logic set_err, set_stuff, push, ovf, do_rd, do_wr;

    assign line_raw = {d_plus, d_minus};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            // Two-flop synchroniser per line, reset to the idle J level
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    line_meta[gi] <= LINE_J[gi];
                    line_sync[gi] <= LINE_J[gi];
                end else begin
                    line_meta[gi] <= line_raw[gi];
                    line_sync[gi] <= line_meta[gi];
                end
            end
        end
    endgenerate

    assign dp_sync    = line_sync[1];
    assign dm_sync    = line_sync[0];
    assign dp_edge    = dp_sync ^ dp_prev_reg;
    assign dp_fall    = dp_prev_reg & ~dp_sync;
    assign strobe     = (timer_reg == TIMER_MID);
    assign eop        = strobe & ~dp_sync & ~dm_sync;
    assign j_seen     = strobe & dp_sync & ~dm_sync;
    assign dec_bit    = (dp_sync == last_reg);
    assign stuff_slot = (ones_reg == 3'd6);
    assign new_byte   = {dec_bit, shift_reg[7:1]};
    assign rcving     = (state_reg != IDLE);
    assign start      = (state_reg == IDLE) && dp_fall;

    // Edge history of synced D+ and the bit timer, resynced on every D+ edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_prev_reg <= 1'b1;
            timer_reg   <= '0;
        end else begin
            dp_prev_reg <= dp_sync;
            if (start || (rcving && dp_edge) || timer_reg == TIMER_MAX)
                timer_reg <= '0;
            else
                timer_reg <= timer_reg + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic and per-cycle event strobes; EOP has priority over data
    always_comb begin
        state_next = state_reg;
        set_err    = 1'b0;
        set_stuff  = 1'b0;
        push       = 1'b0;
        case (state_reg)
            IDLE: if (dp_fall) state_next = SYNC;
            SYNC: begin
                if (eop) begin
                    set_err    = 1'b1;
                    state_next = EOP_WAIT;
                end else if (strobe && bit_cnt_reg == 3'd7) begin
                    if (new_byte == SYNC_PATTERN) begin
                        state_next = RECV;
                    end else begin
                        set_err    = 1'b1;
                        state_next = ERR_WAIT;
                    end
                end
            end
            RECV: begin
                if (eop) begin
                    if (bit_cnt_reg != 3'd0) set_err = 1'b1;
                    state_next = EOP_WAIT;
                end else if (strobe) begin
                    if (stuff_slot) begin
                        if (dec_bit) begin
                            set_err    = 1'b1;
                            set_stuff  = 1'b1;
                            state_next = ERR_WAIT;
                        end
                    end else if (bit_cnt_reg == 3'd7) begin
                        push = 1'b1;
                    end
                end
            end
            ERR_WAIT: if (eop) state_next = EOP_WAIT;
            EOP_WAIT: if (j_seen) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Bit-level datapath: NRZI history, ones run, shift register, bit count
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt_reg <= '0;
            ones_reg    <= '0;
            last_reg    <= 1'b1;
            shift_reg   <= '0;
        end else if (start) begin
            bit_cnt_reg <= '0;
            ones_reg    <= '0;
            last_reg    <= 1'b1;
            shift_reg   <= '0;
        end else if (strobe && !eop && (state_reg == SYNC || state_reg == RECV)) begin
            last_reg <= dp_sync;
            if (state_reg == RECV && stuff_slot) begin
                ones_reg <= '0;
            end else begin
                // Saturate so an unusual SYNC pattern cannot wrap the run count
                ones_reg    <= dec_bit ? (stuff_slot ? ones_reg : ones_reg + 3'd1) : 3'd0;
                shift_reg   <= new_byte;
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
        end
    end

    // Completed byte is written to the FIFO one cycle after assembly
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_pending_reg <= 1'b0;
            wr_byte_reg    <= '0;
        end else begin
            wr_pending_reg <= push;
            if (push) wr_byte_reg <= new_byte;
        end
    end

    assign do_rd = r_enable && (count_reg != '0);
    assign do_wr = wr_pending_reg && (!full || do_rd);
    assign ovf   = wr_pending_reg && full && !r_enable;

    // Sticky packet flags, cleared only when the next packet starts
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_error_reg     <= 1'b0;
            stuff_error_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else if (start) begin
            r_error_reg     <= 1'b0;
            stuff_error_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            if (set_err || ovf) r_error_reg     <= 1'b1;
            if (set_stuff)      stuff_error_reg <= 1'b1;
            if (ovf)            overflow_reg    <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_byte_reg;
    end

    // FIFO pointers and occupancy; power-of-two depth wraps naturally
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(do_wr) - CW'(do_rd);
        end
    end

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CW'(FIFO_DEPTH));
    assign count       = count_reg;
    assign r_data      = empty ? 8'h00 : mem[rd_ptr_reg];
    assign r_error     = r_error_reg;
    assign stuff_error = stuff_error_reg;
    assign overflow    = overflow_reg;
endmodule

// File: doc/usb_rx_param.md
Name: usb_rx_param

Overview:
Parametrised USB full-speed packet receiver, the next generation of the lab receiver. It handles synchronisation, edge resync, NRZI decode, bit unstuffing, SYNC check, EOP detection and byte assembly, and buffers bytes in a configurable FIFO. Compared with the previous receiver it adds configurable oversampling and FIFO depth, stuff-error and overflow detection, and a FIFO occupancy count. It sits between the D+/D- pins and the host-side byte reader.

Parameters:
CLKS_PER_BIT, 8, clocks per USB bit period; must be even and >=4.
FIFO_DEPTH, 8, FIFO entries; power of two, >=2.
SYNC_PATTERN, 8'h80, decoded SYNC byte, LSB-first.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
d_plus  input  1  raw D+ line, asynchronous.
d_minus  input  1  raw D- line, asynchronous.
r_enable  input  1  pop one byte from the FIFO.
r_data  output  8  FIFO head byte; valid while empty=0.
empty  output  1  FIFO empty.
full  output  1  FIFO full.
count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
rcving  output  1  packet in progress.
r_error  output  1  packet error flag.
stuff_error  output  1  sticky bit-stuff violation in current/last packet.
overflow  output  1  sticky FIFO overflow in current/last packet.

Behaviour:
- Reset values: rcving=0, r_error=0, stuff_error=0, overflow=0, empty=1, full=0, count=0, r_data=0.
- Reset state of internal datapath: FIFO pointers=0, FSM=IDLE. Synchronisers reset to J (D+=1, D-=0). Previous-bit register=1.
- Synchronisation: two-flop synchronisers on both lines; all logic uses the synchronised values.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. Any synced D+ edge while rcving=1 forces it to 0. Sample strobe fires at count==CLKS_PER_BIT/2.
- NRZI decode: decoded bit=1 if sampled D+ equals the previous sample, else 0.
- Unstuffing: ones-counter increments on a decoded 1 and clears on a 0. After 6 ones, the next sampled bit is discarded and the counter cleared. If that discarded bit is 1, stuff_error=1, r_error=1 and the FSM goes to ERR_WAIT.
- EOP: synced D+=0 and D-=0 at a sample strobe.
- IDLE: on the first synced D+ falling edge, go to SYNC. rcving=1. The bit timer, ones-counter and bit counter clear. r_error, stuff_error and overflow clear.
- SYNC: shift 8 decoded bits LSB-first. If they equal SYNC_PATTERN, go to RECV; otherwise r_error=1 and go to ERR_WAIT. EOP in SYNC: r_error=1, go to EOP_WAIT.
- RECV: shift unstuffed bits LSB-first. On the 8th bit, write the byte to the FIFO in the next cycle.
  - If the FIFO is full and there is no simultaneous read, the byte is dropped and overflow=1, r_error=1.
  - EOP with bit count 0 goes to EOP_WAIT with no error.
  - EOP with bit count 1..7 drops the partial byte, sets r_error=1, and goes to EOP_WAIT.
- ERR_WAIT: ignore data until EOP, then go to EOP_WAIT.
- EOP_WAIT: wait for synced J (D+=1, D-=0) at a sample strobe, then go to IDLE with rcving=0.
- Error flags are held until the next packet start.
- FIFO: circular buffer; count is exact.
  - r_enable with empty=1 is ignored.
  - Simultaneous read and write when full: both occur and count is unchanged.
  - Simultaneous read and write when empty: the write occurs and the read is ignored.
  - Pointers wrap modulo FIFO_DEPTH. r_data is the combinational head entry.
- Reset mid-packet: immediate return to the reset state; FIFO contents are discarded.

Test Plan:
- Reset, idle J: empty=1, count=0, rcving=0, all error flags 0.
- Clean packet SYNC + 8'hA5 + 8'h3C + EOP, CLKS_PER_BIT=8: rcving rises within 3 clks of the first K. Bytes A5, 3C are popped in order. r_error=0, count returns to 0.
- Byte 8'hFF followed by 8'h01 (stuffed 0 after six 1s): 8'hFF and 8'h01 are received with no stuff_error. Same stream with the stuffed bit forced to 1: stuff_error=1, r_error=1, no byte written after the violation.
- Bad SYNC 8'h81: r_error=1, nothing written, return to IDLE after EOP. The next good packet clears r_error.
- FIFO_DEPTH=4, 5 bytes with no reads: full=1 after 4 bytes, 5th byte dropped, overflow=1, count=4. Bytes 1-4 read back intact; pointer wrap is checked with a following packet.
- EOP after 3 data bits: r_error=1, count unchanged. Assert n_rst mid-byte: all outputs return to reset values the same cycle.
